// File: rtl/axis_arb_pkg.sv
// ---------------------------------------------------------------------------
// axis_arb_pkg
// Shared types and helpers for the AXI-Stream round-robin arbiter.
//   arb_state_t : two-state arbitration FSM encoding (IDLE / GRANT)
//   MAX_SRC     : widest request vector the helpers accept
//   tid_width   : width of the source-index field, never below 1 bit
//   cnt_width   : width of the per-grant beat counter, never below 1 bit
//   rr_first    : first requesting index at or after ptr, wrapping modulo n
// ---------------------------------------------------------------------------
package axis_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  localparam int MAX_SRC = 16;

  function automatic int tid_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int cnt_width(input int max_burst);
    return (max_burst <= 0) ? 1 : $clog2(max_burst + 1);
  endfunction

  // Returns -1 when nothing requests. The scan runs from the far end back
  // toward ptr so that the last assignment is the nearest requester.
  function automatic int rr_first(input logic [MAX_SRC-1:0] req,
                                  input int ptr,
                                  input int n);
    int         found;
    logic [3:0] j;
    found = -1;
    for (int k = n - 1; k >= 0; k--) begin
      j = 4'((ptr + k) % n);
      if (req[j]) begin
        found = int'(j);
      end
    end
    return found;
  endfunction

endpackage

// File: rtl/axis_rr_pick.sv
// ---------------------------------------------------------------------------
// axis_rr_pick
// Purely combinational rotate-priority encoder.
//   req  : per-source request bits
//   ptr  : index that has highest priority this round
//   idx  : first requesting index at or after ptr (wrapping); 0 if none
//   any  : at least one request is present
// ---------------------------------------------------------------------------
module axis_rr_pick
  import axis_arb_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  logic [MAX_SRC-1:0] req_wide;
  int                 first_idx;

  // Zero-pad the request vector to the helper's fixed width.
  for (genvar gi = 0; gi < MAX_SRC; gi++) begin : g_pad
    if (gi < NUM_SRC) begin : g_live
      assign req_wide[gi] = req[gi];
    end else begin : g_dead
      assign req_wide[gi] = 1'b0;
    end
  end

  always_comb begin
    first_idx = rr_first(req_wide, int'(ptr), NUM_SRC);
    any       = |req;
    idx       = (first_idx < 0) ? '0 : IDX_W'(first_idx);
  end

endmodule

// File: rtl/axis_stream_arbiter.sv
// ---------------------------------------------------------------------------
// axis_stream_arbiter
// Packet-aware round-robin merge of NUM_SRC AXI-Stream sources onto one
// AXI-Stream master. A grant is held until a beat with tlast transfers, or
// until MAX_BURST beats have moved (MAX_BURST = 0 means tlast only), after
// which the round-robin pointer moves past the released source. Every grant
// is preceded by one IDLE arbitration cycle.
//
// Ports
//   axis_clk, axis_rst_n          : clock, asynchronous active-low reset
//   s_axis_tvalid/tready/tlast    : per-source handshake and end-of-packet
//   s_axis_tdata                  : source i at [i*DATA_WIDTH +: DATA_WIDTH]
//   m_axis_tvalid/tready/tlast    : merged stream handshake
//   m_axis_tdata                  : merged data
//   m_axis_tid                    : index of the granted source
// ---------------------------------------------------------------------------
module axis_stream_arbiter
  import axis_arb_pkg::*;
#(
  parameter  int NUM_SRC    = 4,
  parameter  int DATA_WIDTH = 4,
  parameter  int MAX_BURST  = 8,
  localparam int TID_W      = tid_width(NUM_SRC)
) (
  input  logic                          axis_clk,
  input  logic                          axis_rst_n,
  input  logic [NUM_SRC-1:0]            s_axis_tvalid,
  output logic [NUM_SRC-1:0]            s_axis_tready,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_SRC-1:0]            s_axis_tlast,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic                          m_axis_tlast,
  output logic [TID_W-1:0]              m_axis_tid
);

  localparam int CNT_W = cnt_width(MAX_BURST);
  // Counter value of the beat that, once transferred, exhausts the burst.
  localparam logic [CNT_W-1:0] BURST_LAST =
    CNT_W'((MAX_BURST > 0) ? (MAX_BURST - 1) : 0);

  arb_state_t       state_reg, state_next;
  logic [TID_W-1:0] grant_reg, grant_next;
  logic [TID_W-1:0] rr_ptr_reg, rr_ptr_next;
  logic [CNT_W-1:0] beat_cnt_reg, beat_cnt_next;

  logic [TID_W-1:0] pick_idx;
  logic             pick_any;

  logic [NUM_SRC-1:0]    hit;
  logic [DATA_WIDTH-1:0] data_term [NUM_SRC];
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  sel_valid;
  logic                  sel_last;
  logic                  xfer;
  logic                  burst_done;
  logic                  release_beat;
  logic [TID_W-1:0]      ptr_after_grant;

  // -------------------------------------------------------------------------
  // Round-robin choice among current requesters
  // -------------------------------------------------------------------------
  axis_rr_pick #(
    .NUM_SRC (NUM_SRC),
    .IDX_W   (TID_W)
  ) u_pick (
    .req (s_axis_tvalid),
    .ptr (rr_ptr_reg),
    .idx (pick_idx),
    .any (pick_any)
  );

  // -------------------------------------------------------------------------
  // Granted-source mux, built as one-hot AND-OR so no index arithmetic
  // depends on NUM_SRC being a power of two.
  // -------------------------------------------------------------------------
  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_sel
    assign hit[gi]       = (grant_reg == TID_W'(gi));
    assign data_term[gi] = hit[gi] ? s_axis_tdata[gi*DATA_WIDTH +: DATA_WIDTH]
                                   : '0;
  end

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      sel_data = sel_data | data_term[i];
    end
  end

  assign sel_valid = |(s_axis_tvalid & hit);
  assign sel_last  = |(s_axis_tlast & hit);

  assign xfer         = (state_reg == GRANT) && sel_valid && m_axis_tready;
  assign burst_done   = (MAX_BURST != 0) && (beat_cnt_reg == BURST_LAST);
  assign release_beat = xfer && (sel_last || burst_done);

  assign ptr_after_grant = (grant_reg == TID_W'(NUM_SRC - 1)) ? '0
                                                              : grant_reg + TID_W'(1);

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      state_reg    <= IDLE;
      grant_reg    <= '0;
      rr_ptr_reg   <= '0;
      beat_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      grant_reg    <= grant_next;
      rr_ptr_reg   <= rr_ptr_next;
      beat_cnt_reg <= beat_cnt_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next    = state_reg;
    grant_next    = grant_reg;
    rr_ptr_next   = rr_ptr_reg;
    beat_cnt_next = beat_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (pick_any) begin
          grant_next    = pick_idx;
          beat_cnt_next = '0;
          state_next    = GRANT;
        end
      end
      GRANT: begin
        if (release_beat) begin
          state_next    = IDLE;
          rr_ptr_next   = ptr_after_grant;
          beat_cnt_next = '0;
        end else if (xfer) begin
          // With no burst cap the count is never consulted, so keep it at 0.
          beat_cnt_next = (MAX_BURST == 0) ? '0 : beat_cnt_reg + CNT_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Output logic: everything is quiet outside GRANT, which also covers reset
  // because the state register clears asynchronously.
  // -------------------------------------------------------------------------
  always_comb begin
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tlast  = 1'b0;
    m_axis_tid    = '0;
    s_axis_tready = '0;
    if (state_reg == GRANT) begin
      m_axis_tvalid = sel_valid;
      m_axis_tdata  = sel_data;
      m_axis_tlast  = sel_last;
      m_axis_tid    = grant_reg;
      s_axis_tready = hit & {NUM_SRC{m_axis_tready}};
    end
  end

endmodule

// File: tb/tb_axis_stream_arbiter.sv
// ---------------------------------------------------------------------------
// tb_axis_stream_arbiter
// Randomised and directed stimulus for axis_stream_arbiter (4 sources,
// 4-bit data, bursts capped at 8). A transaction-level model tracks which
// source owns the output and predicts every output on every cycle; directed
// scenarios additionally pin exact beat timing with literal expectations.
// ---------------------------------------------------------------------------
module tb_axis_stream_arbiter;

  localparam int N  = 4;
  localparam int DW = 4;
  localparam int MB = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  s_tvalid;
  logic [N-1:0]  s_tready;
  logic [N*DW-1:0] s_tdata;
  logic [N-1:0]  s_tlast;
  logic          m_tvalid;
  logic          m_tready;
  logic [DW-1:0] m_tdata;
  logic          m_tlast;
  logic [1:0]    m_tid;

  axis_stream_arbiter #(
    .NUM_SRC    (N),
    .DATA_WIDTH (DW),
    .MAX_BURST  (MB)
  ) dut (
    .axis_clk      (clk),
    .axis_rst_n    (rst_n),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .s_axis_tdata  (s_tdata),
    .s_axis_tlast  (s_tlast),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tlast  (m_tlast),
    .m_axis_tid    (m_tid)
  );

  always #5 clk = ~clk;

  // Source queues: {last, data} per beat.
  logic [4:0] mem [N][256];
  int         head [N];
  int         tail [N];
  logic [N-1:0] en = '0;
  logic       rdy = 1'b1;
  logic [N-1:0] acc = '0;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int lg_tid  [4096];
  int lg_data [4096];
  int lg_last [4096];
  int lg_cyc  [4096];
  int lg_n = 0;

  // Model: owner = -1 while no source holds the output.
  int owner = -1;
  int ptr   = 0;
  int beats = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic chk_log(input string name, input int base, input int idx,
                         input int tid, input int data, input int last,
                         input int when);
    int p;
    p = base + idx;
    total++;
    if (p >= lg_n) begin
      bad++;
      $display("FAIL %s beat %0d missing (only %0d logged)", name, idx, lg_n - base);
    end else if (lg_tid[p] != tid || lg_data[p] != data ||
                 lg_last[p] != last || lg_cyc[p] != when) begin
      bad++;
      $display("FAIL %s beat %0d actual tid=%0d data=%0h last=%0d cyc=%0d required tid=%0d data=%0h last=%0d cyc=%0d",
               name, idx, lg_tid[p], lg_data[p], lg_last[p], lg_cyc[p],
               tid, data, last, when);
    end
  endtask

  task automatic drive();
    logic [4:0] e;
    for (int i = 0; i < N; i++) begin
      e = mem[i][head[i] % 256];
      if (en[i] && head[i] != tail[i]) begin
        s_tvalid[i]        = 1'b1;
        s_tdata[i*DW +: DW] = e[3:0];
        s_tlast[i]         = e[4];
      end else begin
        s_tvalid[i]        = 1'b0;
        s_tdata[i*DW +: DW] = '0;
        s_tlast[i]         = 1'b0;
      end
    end
    m_tready = rdy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (acc[i]) head[i]++;
    end
    drive();
  endtask

  task automatic push(input int src, input int data, input int last);
    mem[src][tail[src] % 256] = {1'(last), 4'(data)};
    tail[src]++;
  endtask

  task automatic clear_queues();
    en = '0;
    for (int i = 0; i < N; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
  endtask

  task automatic do_reset();
    tick();
    rst_n = 1'b0;
    clear_queues();
    rdy = 1'b1;
    drive();
    tick();
    tick();
    rst_n = 1'b1;
    drive();
  endtask

  // -------------------------------------------------------------------------
  // Compare process: predict outputs from the model, check, then advance.
  // -------------------------------------------------------------------------
  always @(negedge clk) begin : cmp
    int         ev, et, ed, el;
    logic [N-1:0] er;
    int         nxt;
    int         j;
    if (!rst_n) begin
      owner = -1;
      ptr   = 0;
      beats = 0;
    end
    if (owner < 0) begin
      ev = 0; ed = 0; el = 0; et = 0; er = '0;
    end else begin
      ev = int'(s_tvalid[owner]);
      ed = int'(s_tdata[owner*DW +: DW]);
      el = int'(s_tlast[owner]);
      et = owner;
      er = m_tready ? N'(1 << owner) : '0;
    end
    chk("m_tvalid", int'(m_tvalid), ev);
    chk("s_tready", int'(s_tready), int'(er));
    chk("m_tdata",  int'(m_tdata),  ed);
    chk("m_tlast",  int'(m_tlast),  el);
    chk("m_tid",    int'(m_tid),    et);

    acc = s_tvalid & s_tready;

    if (m_tvalid && m_tready) begin
      $display("xfer cyc=%0d tid=%0d data=%0h last=%0d", cyc, m_tid, m_tdata, m_tlast);
      if (lg_n < 4096) begin
        lg_tid[lg_n]  = int'(m_tid);
        lg_data[lg_n] = int'(m_tdata);
        lg_last[lg_n] = int'(m_tlast);
        lg_cyc[lg_n]  = cyc;
        lg_n++;
      end
    end

    if (rst_n) begin
      if (owner < 0) begin
        nxt = -1;
        for (int k = 0; k < N; k++) begin
          j = (ptr + k) % N;
          if (nxt < 0 && s_tvalid[j]) nxt = j;
        end
        owner = nxt;
        beats = 0;
      end else if (s_tvalid[owner] && m_tready) begin
        beats++;
        if (s_tlast[owner] || beats == MB) begin
          ptr   = (owner + 1) % N;
          owner = -1;
          beats = 0;
        end
      end
    end
    cyc++;
  end

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  initial begin : stim
    int base, base2, k, k2, k3;
    rst_n = 1'b0;
    clear_queues();
    drive();
    tick();
    tick();
    #1;
    chk("rst_m_tvalid", int'(m_tvalid), 0);
    chk("rst_s_tready", int'(s_tready), 0);
    chk("rst_m_tid",    int'(m_tid),    0);
    chk("rst_m_tdata",  int'(m_tdata),  0);
    chk("rst_m_tlast",  int'(m_tlast),  0);
    tick();
    rst_n = 1'b1;
    drive();

    // Single source, 3-beat packet, then rr_ptr has moved to 1.
    do_reset();
    tick();
    base = lg_n;
    push(0, 1, 0); push(0, 2, 0); push(0, 3, 1);
    en[0] = 1'b1;
    k = cyc;
    drive();
    #1;
    chk("t1_latency_idle", int'(m_tvalid), 0);
    repeat (5) tick();
    chk_log("t1", base, 0, 0, 1, 0, k + 1);
    chk_log("t1", base, 1, 0, 2, 0, k + 2);
    chk_log("t1", base, 2, 0, 3, 1, k + 3);
    base2 = lg_n;
    push(0, 4, 1); push(1, 5, 1);
    en[1] = 1'b1;
    k = cyc;
    drive();
    repeat (5) tick();
    chk_log("t1_ptr", base2, 0, 1, 5, 1, k + 1);
    chk_log("t1_ptr", base2, 1, 0, 4, 1, k + 3);

    // All four request single-beat packets: 0,1,2,3,0 with bubbles.
    do_reset();
    base = lg_n;
    push(0, 1, 1); push(1, 2, 1); push(2, 3, 1); push(3, 4, 1); push(0, 5, 1);
    en = 4'hF;
    k = cyc;
    drive();
    repeat (12) tick();
    for (int i = 0; i < 5; i++) begin
      chk_log("t2", base, i, i % 4, i + 1, 1, k + 1 + 2 * i);
    end

    // Burst cap: source 2 streams without tlast, source 3 waits.
    do_reset();
    base = lg_n;
    for (int b = 0; b < 20; b++) push(2, b % 16, 0);
    push(3, 10, 0); push(3, 11, 1);
    en = 4'hC;
    k = cyc;
    drive();
    repeat (16) tick();
    for (int b = 0; b < 8; b++) begin
      chk_log("t3_burst", base, b, 2, b, 0, k + 1 + b);
    end
    chk_log("t3_src3", base, 8, 3, 10, 0, k + 10);
    chk_log("t3_src3", base, 9, 3, 11, 1, k + 11);
    chk_log("t3_resume", base, 10, 2, 8, 0, k + 13);

    // Downstream backpressure for 5 cycles mid-packet.
    do_reset();
    base = lg_n;
    push(0, 5, 0); push(0, 6, 0); push(0, 7, 0); push(0, 8, 1);
    en[0] = 1'b1;
    k = cyc;
    drive();
    tick();
    tick();
    tick();
    rdy = 1'b0;
    drive();
    for (int c = 0; c < 5; c++) begin
      if (c > 0) tick();
      #1;
      chk("t4_bp_tready", int'(s_tready), 0);
      chk("t4_bp_tdata",  int'(m_tdata),  7);
    end
    tick();
    rdy = 1'b1;
    drive();
    repeat (3) tick();
    chk_log("t4", base, 0, 0, 5, 0, k + 1);
    chk_log("t4", base, 1, 0, 6, 0, k + 2);
    chk_log("t4", base, 2, 0, 7, 0, k + 8);
    chk_log("t4", base, 3, 0, 8, 1, k + 9);

    // Granted source 1 stalls for 4 cycles while source 0 waits.
    do_reset();
    base = lg_n;
    push(1, 9, 0); push(1, 10, 0); push(1, 11, 1);
    en[1] = 1'b1;
    k = cyc;
    drive();
    tick();
    tick();
    en[1] = 1'b0;
    push(0, 4, 1);
    en[0] = 1'b1;
    drive();
    for (int c = 0; c < 4; c++) begin
      if (c > 0) tick();
      #1;
      chk("t5_gap_valid", int'(m_tvalid), 0);
      chk("t5_gap_tid",   int'(m_tid),    1);
      chk("t5_gap_ready", int'(s_tready), 2);
    end
    tick();
    en[1] = 1'b1;
    drive();
    repeat (5) tick();
    chk_log("t5", base, 0, 1, 9, 0, k + 1);
    chk_log("t5", base, 1, 1, 10, 0, k + 6);
    chk_log("t5", base, 2, 1, 11, 1, k + 7);
    chk_log("t5", base, 3, 0, 4, 1, k + 9);

    // Asynchronous reset mid-packet, then lowest-index requester wins.
    do_reset();
    push(2, 1, 1);
    en[2] = 1'b1;
    drive();
    repeat (3) tick();
    base = lg_n;
    for (int b = 1; b <= 6; b++) push(3, b, (b == 6) ? 1 : 0);
    push(1, 7, 1);
    en = 4'b1110;
    k2 = cyc;
    drive();
    repeat (3) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_valid", int'(m_tvalid), 0);
    chk("t6_async_ready", int'(s_tready), 0);
    chk("t6_async_tid",   int'(m_tid),    0);
    chk_log("t6_pre", base, 0, 3, 1, 0, k2 + 1);
    tick();
    clear_queues();
    drive();
    tick();
    push(1, 7, 1); push(3, 12, 1);
    en = 4'b1010;
    rst_n = 1'b1;
    base2 = lg_n;
    k3 = cyc;
    drive();
    repeat (5) tick();
    chk_log("t6_post", base2, 0, 1, 7, 1, k3 + 1);
    chk_log("t6_post", base2, 1, 3, 12, 1, k3 + 3);

    // Randomised traffic against the model.
    do_reset();
    base = lg_n;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (tail[i] - head[i] < 8) begin
          int len;
          len = int'($urandom_range(1, 6));
          for (int b = 0; b < len; b++) begin
            push(i, int'($urandom_range(0, 15)), (b == len - 1) ? 1 : 0);
          end
        end
        en[i] = ($urandom_range(0, 9) != 0);
      end
      rdy = ($urandom_range(0, 3) != 0);
      drive();
      tick();
    end
    total++;
    if (lg_n - base < 500) begin
      bad++;
      $display("FAIL rand_flow actual=%0d beats required>=500", lg_n - base);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
